// File: rtl/disk_pkg.sv
//------------------------------------------------------------------------------
// Module      : disk_pkg
// Description : Disk MMIO register map, command opcodes and sequencer states.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package disk_pkg;

  localparam logic [11:0] c_addr_cmd  = 12'h100;
  localparam logic [11:0] c_addr_stat = 12'h101;
  localparam logic [11:0] c_addr_data = 12'h102;

  localparam logic [31:0] c_dcmd_read  = 32'h0000_0001;
  localparam logic [31:0] c_dcmd_write = 32'h0000_0002;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_WAIT = 3'd2,
    ST_XFER = 3'd3,
    ST_RCAP = 3'd4,
    ST_STAT = 3'd5,
    ST_CAP  = 3'd6,
    ST_FIN  = 3'd7
  } xfer_state_e;

endpackage

`default_nettype wire

// File: rtl/disk_xfer_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : disk_xfer_ctrl_if
// Description : Disk MMIO port: address, read/write strobes, data buses, busy.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface disk_xfer_ctrl_if;
  logic [11:0] disk_addr;
  logic        disk_rd;
  logic        disk_wr;
  logic [31:0] disk_wdata;
  logic [31:0] disk_rdata;
  logic        disk_busy;

  modport master (
    output disk_addr, disk_rd, disk_wr, disk_wdata,
    input  disk_rdata, disk_busy
  );

  modport slave (
    input  disk_addr, disk_rd, disk_wr, disk_wdata,
    output disk_rdata, disk_busy
  );
endinterface

`default_nettype wire

// File: rtl/disk_busy_timer.sv
//------------------------------------------------------------------------------
// Module      : disk_busy_timer
// Description : Stall counter; expire flags the enabled cycle that reaches all-ones.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module disk_busy_timer #(
  parameter int unsigned TMO_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMO_W-1:0] c_last = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the increment that takes the counter to all-ones.
  assign expire = en && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/disk_xfer_ctrl.sv
//------------------------------------------------------------------------------
// Module      : disk_xfer_ctrl
// Description : Turns one host request into a Disk CMD write, per-word DATA access and STAT read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module disk_xfer_ctrl
  import disk_pkg::*;
#(
  parameter logic [11:0] ADDR_CMD  = c_addr_cmd,
  parameter logic [11:0] ADDR_STAT = c_addr_stat,
  parameter logic [11:0] ADDR_DATA = c_addr_data,
  parameter int unsigned TMO_W     = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_cmd,
  input  logic [7:0]  req_count,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [31:0] status,
  output logic        timeout,
  disk_xfer_ctrl_if.master disk
);

  xfer_state_e r_state, w_state_nxt;
  logic        r_write, w_write_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_req_ready, w_req_ready_nxt;
  logic        r_wr_ready, w_wr_ready_nxt;
  logic        r_rd_valid, w_rd_valid_nxt;
  logic [31:0] r_rd_data, w_rd_data_nxt;
  logic        r_done, w_done_nxt;
  logic [31:0] r_status, w_status_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic [11:0] r_addr, w_addr_nxt;
  logic        r_rd, w_rd_nxt;
  logic        r_wr, w_wr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;

  logic w_tmo_en;
  logic w_tmo_clr;
  logic w_tmo_expire;

  // A WAIT cycle stalls on busy, or on a write with no host word available.
  assign w_tmo_en  = (r_state == ST_WAIT) && (disk.disk_busy || (r_write && !wr_valid));
  assign w_tmo_clr = (r_state != ST_WAIT);

  disk_busy_timer #(
    .TMO_W (TMO_W)
  ) u_busy_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_tmo_clr),
    .en     (w_tmo_en),
    .expire (w_tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_status    <= '0;
      r_timeout   <= 1'b0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_write     <= w_write_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_wr_ready  <= w_wr_ready_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_done      <= w_done_nxt;
      r_status    <= w_status_nxt;
      r_timeout   <= w_timeout_nxt;
      r_addr      <= w_addr_nxt;
      r_rd        <= w_rd_nxt;
      r_wr        <= w_wr_nxt;
      r_wdata     <= w_wdata_nxt;
    end
  end

  // Outputs are registered: each branch sets the values seen during the next state.
  always_comb begin
    w_state_nxt     = r_state;
    w_write_nxt     = r_write;
    w_cnt_nxt       = r_cnt;
    w_req_ready_nxt = 1'b0;
    w_wr_ready_nxt  = 1'b0;
    w_rd_valid_nxt  = 1'b0;
    w_rd_data_nxt   = r_rd_data;
    w_done_nxt      = 1'b0;
    w_status_nxt    = r_status;
    w_timeout_nxt   = r_timeout;
    w_addr_nxt      = r_addr;
    w_rd_nxt        = 1'b0;
    w_wr_nxt        = 1'b0;
    w_wdata_nxt     = r_wdata;

    case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid && r_req_ready) begin
          w_state_nxt     = ST_CMD;
          w_req_ready_nxt = 1'b0;
          w_write_nxt     = req_write;
          w_cnt_nxt       = req_count;
          w_timeout_nxt   = 1'b0;
          w_wr_nxt        = 1'b1;
          w_addr_nxt      = ADDR_CMD;
          w_wdata_nxt     = req_cmd;
        end
      end
      ST_CMD: begin
        if (r_cnt != 8'd0) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_STAT;
          w_rd_nxt    = 1'b1;
          w_addr_nxt  = ADDR_STAT;
        end
      end
      ST_WAIT: begin
        if (!w_tmo_en) begin
          w_state_nxt = ST_XFER;
          w_addr_nxt  = ADDR_DATA;
          if (r_write) begin
            w_wr_nxt       = 1'b1;
            w_wdata_nxt    = wr_data;
            w_wr_ready_nxt = 1'b1;
          end else begin
            w_rd_nxt = 1'b1;
          end
        end else if (w_tmo_expire) begin
          w_state_nxt   = ST_FIN;
          w_done_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
        end
      end
      ST_XFER: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (!r_write) begin
          w_state_nxt = ST_RCAP;
        end else if (r_cnt == 8'd1) begin
          w_state_nxt = ST_STAT;
          w_rd_nxt    = 1'b1;
          w_addr_nxt  = ADDR_STAT;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RCAP: begin
        w_rd_data_nxt  = disk.disk_rdata;
        w_rd_valid_nxt = 1'b1;
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_STAT;
          w_rd_nxt    = 1'b1;
          w_addr_nxt  = ADDR_STAT;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_STAT: begin
        w_state_nxt = ST_CAP;
      end
      ST_CAP: begin
        w_status_nxt = disk.disk_rdata;
        w_state_nxt  = ST_FIN;
        w_done_nxt   = 1'b1;
      end
      ST_FIN: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  assign req_ready       = r_req_ready;
  assign wr_ready        = r_wr_ready;
  assign rd_valid        = r_rd_valid;
  assign rd_data         = r_rd_data;
  assign done            = r_done;
  assign status          = r_status;
  assign timeout         = r_timeout;
  assign disk.disk_addr  = r_addr;
  assign disk.disk_rd    = r_rd;
  assign disk.disk_wr    = r_wr;
  assign disk.disk_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_disk_xfer_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_disk_xfer_ctrl
// Description : Directed bench for disk_xfer_ctrl with a small Disk responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_disk_xfer_ctrl;
  import disk_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_cmd;
  logic [7:0]  req_count;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic [31:0] status;
  logic        timeout;

  disk_xfer_ctrl_if dif ();

  disk_xfer_ctrl #(
    .TMO_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_cmd   (req_cmd),
    .req_count (req_count),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .status    (status),
    .timeout   (timeout),
    .disk      (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Disk responder: registered read data, busy held busy_len cycles after each strobe.
  int          busy_len   = 0;
  logic        busy_stuck = 1'b0;
  int          busy_cnt   = 0;
  int          rd_idx     = 0;
  logic [31:0] stat_val   = 32'h0;
  logic [31:0] m_rdata    = 32'h0;

  always @(posedge clk) begin
    if (dif.disk_rd || dif.disk_wr) busy_cnt <= busy_len;
    else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
    if (dif.disk_rd) begin
      if (dif.disk_addr == c_addr_data) begin
        m_rdata <= 32'hDEAD0001 + rd_idx;
        rd_idx  <= rd_idx + 1;
      end else if (dif.disk_addr == c_addr_stat) begin
        m_rdata <= stat_val;
      end
    end
  end

  assign dif.disk_rdata = m_rdata;
  assign dif.disk_busy  = busy_stuck || (busy_cnt != 0);

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  logic [11:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_wr[$];
  logic [31:0] rdv_log[$];
  int          both_err = 0;
  int          wr_ready_n = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  int          cmd_n = 0;
  int          last_cmd_cyc = 0;
  int          dwr_n = 0;
  int          acc_cyc = 0;
  logic [31:0] wr_words[4];
  int          wr_idx = 0;
  int          wr_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: step to the falling edge and record what the DUT shows there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (dif.disk_rd && dif.disk_wr) both_err++;
    if (dif.disk_rd || dif.disk_wr) begin
      log_addr.push_back(dif.disk_addr);
      log_data.push_back(dif.disk_wr ? dif.disk_wdata : 32'h0);
      log_wr.push_back(dif.disk_wr);
      if (dif.disk_wr && dif.disk_addr == c_addr_cmd) begin
        cmd_n++;
        last_cmd_cyc = cyc;
      end
      if (dif.disk_wr && dif.disk_addr == c_addr_data) dwr_n++;
    end
    if (rd_valid) rdv_log.push_back(rd_data);
    if (wr_ready) begin
      wr_ready_n++;
      wr_idx++;
      if (wr_idx < wr_n) wr_data = wr_words[wr_idx];
      else               wr_valid = 1'b0;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] cmd, input logic [7:0] cnt);
    req_valid = 1'b1;
    req_write = wr;
    req_cmd   = cmd;
    req_count = cnt;
    tick();
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int d0;
    d0 = done_n;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (done_n != d0) break;
    end
    check(tag, done_n - d0, 1);
  endtask

  initial begin
    int n0;
    int w0;
    int r0;
    int hit;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_cmd = '0; req_count = '0;
    wr_data = '0; wr_valid = 1'b0;
    repeat (3) tick();

    check("rst_req_ready", req_ready, 1);
    check("rst_disk_rd",   dif.disk_rd, 0);
    check("rst_disk_wr",   dif.disk_wr, 0);
    check("rst_wr_ready",  wr_ready, 0);
    check("rst_rd_valid",  rd_valid, 0);
    check("rst_done",      done, 0);
    check("rst_timeout",   timeout, 0);
    check("rst_disk_addr", dif.disk_addr, 0);
    check("rst_wdata",     dif.disk_wdata, 0);
    check("rst_status",    status, 0);
    check("rst_rd_data",   rd_data, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Command only, busy low.
    stat_val = 32'h0000_00A5;
    n0 = log_addr.size();
    do_req(1'b0, 32'h11, 8'd0);
    wait_done("t1_done", 20);
    check("t1_latency",  done_cyc - acc_cyc, 3);
    check("t1_nstrobe",  log_addr.size() - n0, 2);
    check("t1_cmd_addr", log_addr[n0], 12'h100);
    check("t1_cmd_data", log_data[n0], 32'h11);
    check("t1_cmd_wr",   log_wr[n0], 1);
    check("t1_stat_addr", log_addr[n0+1], 12'h101);
    check("t1_stat_rd",   log_wr[n0+1], 0);
    check("t1_status",    status, 32'h0000_00A5);
    tick();
    check("t1_ready_back", req_ready, 1);

    // Write three words with busy high 5 cycles after each strobe.
    busy_len = 5; stat_val = 32'h0000_0B0B;
    wr_words[0] = 32'hAAAA0001; wr_words[1] = 32'hBBBB0002; wr_words[2] = 32'hCCCC0003;
    wr_idx = 0; wr_n = 3; wr_data = wr_words[0]; wr_valid = 1'b1;
    n0 = log_addr.size(); w0 = wr_ready_n;
    do_req(1'b1, c_dcmd_write, 8'd3);
    check("t2_busy_ready", req_ready, 0);
    wait_done("t2_done", 100);
    check("t2_nstrobe", log_addr.size() - n0, 5);
    check("t2_w0_addr", log_addr[n0+1], 12'h102);
    check("t2_w0_data", log_data[n0+1], 32'hAAAA0001);
    check("t2_w1_data", log_data[n0+2], 32'hBBBB0002);
    check("t2_w2_data", log_data[n0+3], 32'hCCCC0003);
    check("t2_w2_addr", log_addr[n0+3], 12'h102);
    check("t2_stat_addr", log_addr[n0+4], 12'h101);
    check("t2_wr_ready_n", wr_ready_n - w0, 3);
    check("t2_status",  status, 32'h0000_0B0B);
    check("t2_timeout", timeout, 0);
    tick();

    // Read two words.
    busy_len = 2; stat_val = 32'h5A5A0003;
    n0 = log_addr.size(); r0 = rdv_log.size();
    do_req(1'b0, c_dcmd_read, 8'd2);
    wait_done("t3_done", 100);
    check("t3_nrdvalid", rdv_log.size() - r0, 2);
    check("t3_rd0", rdv_log[r0], 32'hDEAD0001);
    check("t3_rd1", rdv_log[r0+1], 32'hDEAD0002);
    check("t3_nstrobe", log_addr.size() - n0, 4);
    check("t3_rd_addr", log_addr[n0+1], 12'h102);
    check("t3_status", status, 32'h5A5A0003);
    tick();
    check("t3_single_done", done, 0);

    // Busy stuck high: 15 stalled WAIT cycles then FIN with timeout.
    busy_len = 0; busy_stuck = 1'b1;
    wr_idx = 0; wr_n = 3; wr_data = 32'h1234_5678; wr_valid = 1'b1;
    n0 = log_addr.size(); w0 = wr_ready_n;
    do_req(1'b1, 32'h33, 8'd3);
    wait_done("t4_done", 40);
    check("t4_latency", done_cyc - acc_cyc, 16);
    check("t4_timeout", timeout, 1);
    check("t4_nstrobe", log_addr.size() - n0, 1);
    check("t4_no_wr_ready", wr_ready_n - w0, 0);
    busy_stuck = 1'b0; wr_valid = 1'b0;
    repeat (2) tick();
    check("t4_sticky", timeout, 1);

    // req_valid held high: one accept per transfer, next accept right after done.
    n0 = cmd_n;
    req_valid = 1'b1; req_write = 1'b0; req_cmd = 32'h66; req_count = 8'd0;
    tick();
    check("t6_tmo_clear", timeout, 0);
    check("t6_ready_low", req_ready, 0);
    wait_done("t6_done", 20);
    check("t6_one_accept", cmd_n - n0, 1);
    repeat (2) tick();
    check("t6_second_accept", cmd_n - n0, 2);
    check("t6_accept_cycle", last_cmd_cyc - done_cyc, 2);
    req_valid = 1'b0;
    wait_done("t6_done2", 20);
    tick();

    // Reset during the second of four write words.
    busy_len = 1;
    wr_words[0] = 32'h1000_0001; wr_words[1] = 32'h2000_0002;
    wr_words[2] = 32'h3000_0003; wr_words[3] = 32'h4000_0004;
    wr_idx = 0; wr_n = 4; wr_data = wr_words[0]; wr_valid = 1'b1;
    w0 = dwr_n; hit = 0;
    do_req(1'b1, c_dcmd_write, 8'd4);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (dwr_n - w0 == 2) begin
        hit = 1;
        break;
      end
    end
    check("t5_reached_word2", hit, 1);
    rst_n = 1'b0;
    #1;
    check("t5_wr_drop", dif.disk_wr, 0);
    check("t5_rd_drop", dif.disk_rd, 0);
    check("t5_wr_ready_drop", wr_ready, 0);
    wr_valid = 1'b0;
    n0 = log_addr.size(); r0 = done_n;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t5_ready", req_ready, 1);
    check("t5_no_strobe", log_addr.size() - n0, 0);
    check("t5_no_done", done_n - r0, 0);

    check("no_rd_wr_overlap", both_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
